// File: rtl/gpr_pkg.sv
// Shared widths and the write-back result payload for the GPR write-back path.
package gpr_pkg;

  localparam int unsigned GPR_ADDR_WIDTH  = 5;
  localparam int unsigned GPR_DATA_WIDTH  = 32;
  localparam int unsigned GPR_RS_ID_WIDTH = 5;

  typedef struct packed {
    logic [GPR_ADDR_WIDTH-1:0]  addr;
    logic [GPR_DATA_WIDTH-1:0]  value;
    logic [GPR_RS_ID_WIDTH-1:0] rs_id;
  } wb_result_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded index, pointer advances past each grant.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [IDX_W-1:0] rr_ff;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    int unsigned k;
    k         = 0;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(rr_ff) + i) % N;
      if (!gnt_valid && req[k]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(k);
      end
    end
    gnt[gnt_idx] = gnt_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ff <= '0;
    end else if (gnt_valid) begin
      rr_ff <= (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Write-back arbiter for the GPR write port: round-robin grant, CDB broadcast,
// and register-file write gated by destination ownership.
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int unsigned NUM_UNITS   = 4,
  parameter int unsigned RS_ID_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      unit_valid [NUM_UNITS],
  output logic                      unit_ready [NUM_UNITS],
  input  logic [GPR_ADDR_WIDTH-1:0] unit_addr  [NUM_UNITS],
  input  logic [GPR_DATA_WIDTH-1:0] unit_value [NUM_UNITS],
  input  logic [RS_ID_WIDTH-1:0]    unit_rs_id [NUM_UNITS],
  output logic [GPR_ADDR_WIDTH-1:0] rf_check_addr,
  input  logic                      rf_check_valid,
  input  logic [RS_ID_WIDTH-1:0]    rf_check_rs_id,
  input  logic [GPR_ADDR_WIDTH-1:0] update_addr,
  input  logic                      update_enable,
  output logic [GPR_ADDR_WIDTH-1:0] write_addr,
  output logic                      write_enable,
  output logic [GPR_DATA_WIDTH-1:0] write_value,
  output logic                      cdb_valid,
  output logic [RS_ID_WIDTH-1:0]    cdb_rs_id,
  output logic [GPR_DATA_WIDTH-1:0] cdb_value
);

  localparam int unsigned IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [NUM_UNITS-1:0] req;
  logic [NUM_UNITS-1:0] gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_valid;
  wb_result_t           grant_res;
  logic                 own;

  always_comb begin
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      req[i]        = unit_valid[i];
      unit_ready[i] = gnt[i];
    end
  end

  rr_arbiter #(.N(NUM_UNITS)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Granted unit's payload and the ownership check against the register file.
  always_comb begin
    grant_res.addr  = unit_addr[gnt_idx];
    grant_res.value = unit_value[gnt_idx];
    grant_res.rs_id = GPR_RS_ID_WIDTH'(unit_rs_id[gnt_idx]);
    rf_check_addr   = gnt_valid ? grant_res.addr : '0;
    // A same-cycle update to our destination means a newer producer owns it.
    own = gnt_valid && !rf_check_valid
          && (rf_check_rs_id == RS_ID_WIDTH'(grant_res.rs_id))
          && !(update_enable && (update_addr == grant_res.addr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid    <= 1'b0;
      cdb_rs_id    <= '0;
      cdb_value    <= '0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_value  <= '0;
    end else begin
      cdb_valid    <= gnt_valid;
      write_enable <= own;
      if (gnt_valid) begin
        cdb_rs_id   <= RS_ID_WIDTH'(grant_res.rs_id);
        cdb_value   <= grant_res.value;
        write_addr  <= grant_res.addr;
        write_value <= grant_res.value;
      end
    end
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed self-checking bench for gpr_wb_arbiter.
module tb_gpr_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        unit_valid [4];
  logic        unit_ready [4];
  logic [4:0]  unit_addr  [4];
  logic [31:0] unit_value [4];
  logic [4:0]  unit_rs_id [4];
  logic [4:0]  rf_check_addr;
  logic        rf_check_valid;
  logic [4:0]  rf_check_rs_id;
  logic [4:0]  update_addr;
  logic        update_enable;
  logic [4:0]  write_addr;
  logic        write_enable;
  logic [31:0] write_value;
  logic        cdb_valid;
  logic [4:0]  cdb_rs_id;
  logic [31:0] cdb_value;

  logic [4:0]  rf_rs [32];
  int          n_cmp;
  int          n_bad;

  assign rf_check_rs_id = rf_rs[rf_check_addr];

  gpr_wb_arbiter #(.NUM_UNITS(4), .RS_ID_WIDTH(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .unit_valid     (unit_valid),
    .unit_ready     (unit_ready),
    .unit_addr      (unit_addr),
    .unit_value     (unit_value),
    .unit_rs_id     (unit_rs_id),
    .rf_check_addr  (rf_check_addr),
    .rf_check_valid (rf_check_valid),
    .rf_check_rs_id (rf_check_rs_id),
    .update_addr    (update_addr),
    .update_enable  (update_enable),
    .write_addr     (write_addr),
    .write_enable   (write_enable),
    .write_value    (write_value),
    .cdb_valid      (cdb_valid),
    .cdb_rs_id      (cdb_rs_id),
    .cdb_value      (cdb_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ready_vec();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = unit_ready[i];
    return r;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) begin
      unit_valid[i] = 1'b0;
      unit_addr[i]  = '0;
      unit_value[i] = '0;
      unit_rs_id[i] = '0;
    end
    for (int i = 0; i < 32; i++) rf_rs[i] = '0;
    rf_check_valid = 1'b0;
    update_addr    = '0;
    update_enable  = 1'b0;
  endtask

  // Reset held across two edges, released on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if ({cdb_valid, write_enable} !== 2'b00) begin
      n_bad++; $display("FAIL reset_valids: got %b exp 00", {cdb_valid, write_enable});
    end
    n_cmp++;
    if ({write_addr, write_value, cdb_rs_id, cdb_value} !== '0) begin
      n_bad++; $display("FAIL reset_data: got wa=%0d wv=%h rs=%0d cv=%h", write_addr, write_value, cdb_rs_id, cdb_value);
    end
    n_cmp++;
    if (ready_vec() !== 4'b0000 || rf_check_addr !== 5'd0) begin
      n_bad++; $display("FAIL reset_idle: got ready=%b chk=%0d exp 0000/0", ready_vec(), rf_check_addr);
    end
  endtask

  task automatic test_single();
    do_reset();
    unit_valid[1] = 1'b1; unit_addr[1] = 5'd3; unit_value[1] = 32'hDEADBEEF; unit_rs_id[1] = 5'd7;
    rf_rs[3] = 5'd7;
    #1;
    n_cmp++;
    if (ready_vec() !== 4'b0010 || rf_check_addr !== 5'd3) begin
      n_bad++; $display("FAIL single_grant: got ready=%b chk=%0d exp 0010/3", ready_vec(), rf_check_addr);
    end
    @(posedge clk); #1;
    unit_valid[1] = 1'b0;
    n_cmp++;
    if (cdb_valid !== 1'b1 || cdb_rs_id !== 5'd7 || cdb_value !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL single_cdb: got v=%b rs=%0d val=%h exp 1/7/deadbeef", cdb_valid, cdb_rs_id, cdb_value);
    end
    n_cmp++;
    if (write_enable !== 1'b1 || write_addr !== 5'd3 || write_value !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL single_write: got we=%b wa=%0d wv=%h exp 1/3/deadbeef", write_enable, write_addr, write_value);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (cdb_valid !== 1'b0 || write_enable !== 1'b0 || write_addr !== 5'd3 || cdb_value !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL single_idle_hold: got v=%b we=%b wa=%0d cv=%h exp 0/0/3/deadbeef", cdb_valid, write_enable, write_addr, cdb_value);
    end
  endtask

  task automatic test_fairness();
    int cnt [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      unit_valid[i] = 1'b1; unit_addr[i] = 5'(20 + i);
      unit_value[i] = 32'(32'h100 + i); unit_rs_id[i] = 5'(10 + i);
    end
    for (int c = 0; c < 8; c++) begin
      logic [3:0] exp_r;
      exp_r = 4'b0001 << (c % 4);
      #1;
      for (int i = 0; i < 4; i++) if (unit_ready[i]) cnt[i]++;
      n_cmp++;
      if (ready_vec() !== exp_r) begin
        n_bad++; $display("FAIL fair_ready[%0d]: got %b exp %b", c, ready_vec(), exp_r);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (cdb_valid !== 1'b1 || cdb_rs_id !== 5'(10 + c % 4)) begin
        n_bad++; $display("FAIL fair_cdb[%0d]: got v=%b rs=%0d exp 1/%0d", c, cdb_valid, cdb_rs_id, 10 + c % 4);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (cnt[i] !== 2) begin
        n_bad++; $display("FAIL fair_count[%0d]: got %0d exp 2", i, cnt[i]);
      end
    end
    for (int i = 0; i < 4; i++) unit_valid[i] = 1'b0;
  endtask

  task automatic test_stale();
    do_reset();
    unit_valid[0] = 1'b1; unit_addr[0] = 5'd3; unit_value[0] = 32'h12345678; unit_rs_id[0] = 5'd7;
    rf_rs[3] = 5'd9;
    @(posedge clk); #1;
    unit_valid[0] = 1'b0;
    n_cmp++;
    if (cdb_valid !== 1'b1 || cdb_rs_id !== 5'd7 || write_enable !== 1'b0) begin
      n_bad++; $display("FAIL stale: got v=%b rs=%0d we=%b exp 1/7/0", cdb_valid, cdb_rs_id, write_enable);
    end
    // Register already valid: also no write.
    @(negedge clk);
    rf_rs[3] = 5'd7; rf_check_valid = 1'b1; unit_valid[0] = 1'b1;
    @(posedge clk); #1;
    unit_valid[0] = 1'b0; rf_check_valid = 1'b0;
    n_cmp++;
    if (cdb_valid !== 1'b1 || write_enable !== 1'b0) begin
      n_bad++; $display("FAIL already_valid: got v=%b we=%b exp 1/0", cdb_valid, write_enable);
    end
  endtask

  task automatic test_update();
    do_reset();
    unit_valid[0] = 1'b1; unit_addr[0] = 5'd5; unit_value[0] = 32'hCAFE0005; unit_rs_id[0] = 5'd2;
    rf_rs[5] = 5'd2; update_enable = 1'b1; update_addr = 5'd5;
    @(posedge clk); #1;
    unit_valid[0] = 1'b0;
    n_cmp++;
    if (cdb_valid !== 1'b1 || write_enable !== 1'b0) begin
      n_bad++; $display("FAIL update_same: got v=%b we=%b exp 1/0", cdb_valid, write_enable);
    end
    @(negedge clk);
    unit_valid[0] = 1'b1; update_addr = 5'd6;
    @(posedge clk); #1;
    unit_valid[0] = 1'b0; update_enable = 1'b0;
    n_cmp++;
    if (cdb_valid !== 1'b1 || write_enable !== 1'b1 || write_addr !== 5'd5 || write_value !== 32'hCAFE0005) begin
      n_bad++; $display("FAIL update_other: got v=%b we=%b wa=%0d wv=%h exp 1/1/5/cafe0005", cdb_valid, write_enable, write_addr, write_value);
    end
  endtask

  task automatic test_held();
    int writes12;
    logic [3:0] r;
    writes12 = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      unit_valid[i] = 1'b1; unit_addr[i] = 5'(10 + i);
      unit_value[i] = 32'(32'h22220000 + i); unit_rs_id[i] = 5'(1 + i);
      rf_rs[10 + i] = 5'(1 + i);
    end
    for (int c = 0; c < 5; c++) begin
      #1;
      r = ready_vec();
      n_cmp++;
      if (r !== ((c < 3) ? (4'b0001 << c) : 4'b0000)) begin
        n_bad++; $display("FAIL held_ready[%0d]: got %b exp %b", c, r, (c < 3) ? (4'b0001 << c) : 4'b0000);
      end
      @(posedge clk); #1;
      if (write_enable && write_addr == 5'd12) writes12++;
      for (int i = 0; i < 4; i++) if (r[i]) unit_valid[i] = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (writes12 !== 1) begin
      n_bad++; $display("FAIL held_once: got %0d writes exp 1", writes12);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    unit_valid[0] = 1'b1; unit_addr[0] = 5'd7; unit_value[0] = 32'hA5A5A5A5; unit_rs_id[0] = 5'd5;
    rf_rs[7] = 5'd5;
    unit_valid[1] = 1'b1; unit_addr[1] = 5'd8; unit_value[1] = 32'h5A5A5A5A; unit_rs_id[1] = 5'd6;
    rf_rs[8] = 5'd6;
    @(posedge clk); #1;
    unit_valid[0] = 1'b0;
    n_cmp++;
    if (write_enable !== 1'b1 || write_addr !== 5'd7) begin
      n_bad++; $display("FAIL mid_pre: got we=%b wa=%0d exp 1/7", write_enable, write_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cdb_valid, write_enable, write_addr, write_value, cdb_rs_id, cdb_value} !== '0) begin
      n_bad++; $display("FAIL mid_async: got v=%b we=%b wa=%0d wv=%h rs=%0d cv=%h exp all 0", cdb_valid, write_enable, write_addr, write_value, cdb_rs_id, cdb_value);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (write_enable !== 1'b0 || cdb_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_held: got v=%b we=%b exp 0/0", cdb_valid, write_enable);
    end
    @(negedge clk);
    rst_n = 1'b1;
    unit_valid[0] = 1'b1; unit_valid[3] = 1'b1;
    #1;
    n_cmp++;
    if (ready_vec() !== 4'b0001) begin
      n_bad++; $display("FAIL mid_first_grant: got %b exp 0001", ready_vec());
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) unit_valid[i] = 1'b0;
    n_cmp++;
    if (write_enable !== 1'b1 || write_addr !== 5'd7 || cdb_rs_id !== 5'd5) begin
      n_bad++; $display("FAIL mid_after: got we=%b wa=%0d rs=%0d exp 1/7/5", write_enable, write_addr, cdb_rs_id);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_fairness();
    test_stale();
    test_update();
    test_held();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
